// File: rtl/tag_ram_nway_if.sv
// Request/response bundle for tag_ram_nway: lookup, write and flush inputs,
// registered lookup result and busy outputs.
interface tag_ram_nway_if #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 14,
  parameter int WAYS   = 2
);
  localparam int WWIDTH = $clog2(WAYS);

  logic              flush;
  logic              busy;
  logic              lk_req;
  logic [AWIDTH-1:0] lk_index;
  logic [TWIDTH-1:0] lk_tag;
  logic              wr_en;
  logic [AWIDTH-1:0] wr_index;
  logic [WWIDTH-1:0] wr_way;
  logic [TWIDTH-1:0] wr_tag;
  logic              wr_valid;
  logic              resp_valid;
  logic              hit;
  logic [WWIDTH-1:0] hit_way;
  logic              multi_hit;
  logic [WAYS-1:0]   resp_vmask;

  modport master (
    output flush, lk_req, lk_index, lk_tag, wr_en, wr_index, wr_way, wr_tag, wr_valid,
    input  busy, resp_valid, hit, hit_way, multi_hit, resp_vmask
  );

  modport slave (
    input  flush, lk_req, lk_index, lk_tag, wr_en, wr_index, wr_way, wr_tag, wr_valid,
    output busy, resp_valid, hit, hit_way, multi_hit, resp_vmask
  );
endinterface

// File: rtl/tag_ram_nway.sv
// N-way set-associative tag store with valid bits, 1-cycle registered lookup and
// self-clearing after reset/flush. Macro TAG_RAM_WR_BYPASS_EN selects write-first forwarding.
module tag_ram_nway #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 14,
  parameter int WAYS   = 2
) (
  input logic           clock_i,
  input logic           reset_i,
  tag_ram_nway_if.slave bus
);
  localparam int DEPTH  = 1 << AWIDTH;
  localparam int WWIDTH = $clog2(WAYS);

  typedef enum logic {CLEAR, IDLE} state_e;

  state_e                                  state_q;
  logic [AWIDTH-1:0]                       ptr_q;
  logic [DEPTH-1:0][WAYS-1:0][TWIDTH-1:0]  tag_q;
  logic [DEPTH-1:0][WAYS-1:0]              valid_q;
  logic                                    busy_q;
  logic                                    resp_valid_q;
  logic                                    hit_q;
  logic [WWIDTH-1:0]                       hit_way_q;
  logic                                    multi_q;
  logic [WAYS-1:0]                         vmask_q;

  logic                        lk_acc, wr_acc;
  logic [WAYS-1:0][TWIDTH-1:0] eff_tag;
  logic [WAYS-1:0]             eff_valid;
  logic [WAYS-1:0]             match;
  logic [WWIDTH-1:0]           hit_way_d;
  logic                        multi_d;

  // flush in the same cycle wins over both request types
  assign lk_acc = (state_q == IDLE) && bus.lk_req && !bus.flush;
  assign wr_acc = (state_q == IDLE) && bus.wr_en && !bus.flush && !reset_i;

`ifdef TAG_RAM_WR_BYPASS_EN
  always_comb begin
    eff_tag   = tag_q[bus.lk_index];
    eff_valid = valid_q[bus.lk_index];
    if (wr_acc && (bus.wr_index == bus.lk_index)) begin
      eff_tag[bus.wr_way]   = bus.wr_tag;
      eff_valid[bus.wr_way] = bus.wr_valid;
    end
  end
`else
  assign eff_tag   = tag_q[bus.lk_index];
  assign eff_valid = valid_q[bus.lk_index];
`endif

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign match[w] = eff_valid[w] && (eff_tag[w] == bus.lk_tag);
  end

  always_comb begin
    hit_way_d = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (match[w]) hit_way_d = WWIDTH'(w);
  end

  // clearing the lowest set bit leaves something only if two or more ways matched
  assign multi_d = |(match & (match - {{(WAYS-1){1'b0}}, 1'b1}));

  always_ff @(posedge clock_i) begin
    if (state_q == CLEAR) begin
      tag_q[ptr_q]   <= '0;
      valid_q[ptr_q] <= '0;
    end else if (wr_acc) begin
      tag_q[bus.wr_index][bus.wr_way]   <= bus.wr_tag;
      valid_q[bus.wr_index][bus.wr_way] <= bus.wr_valid;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= CLEAR;
      ptr_q        <= '0;
      busy_q       <= 1'b1;
      resp_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      hit_way_q    <= '0;
      multi_q      <= 1'b0;
      vmask_q      <= '0;
    end else begin
      resp_valid_q <= lk_acc;
      if (lk_acc) begin
        hit_q     <= |match;
        hit_way_q <= hit_way_d;
        multi_q   <= multi_d;
        vmask_q   <= eff_valid;
      end
      case (state_q)
        CLEAR: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == AWIDTH'(DEPTH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (bus.flush) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= CLEAR;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.hit        = hit_q;
  assign bus.hit_way    = hit_way_q;
  assign bus.multi_hit  = multi_q;
  assign bus.resp_vmask = vmask_q;
endmodule

// File: tb/tb_tag_ram_nway.sv
// Directed bench for tag_ram_nway at default parameters (AWIDTH=3, TWIDTH=14, WAYS=2).
module tb_tag_ram_nway;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  tag_ram_nway_if bus ();
  tag_ram_nway dut (.clock_i(clk), .reset_i(rst), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.flush = 0; bus.lk_req = 0; bus.lk_index = '0; bus.lk_tag = '0;
    bus.wr_en = 0; bus.wr_index = '0; bus.wr_way = '0; bus.wr_tag = '0; bus.wr_valid = 0;
  endtask

  task automatic do_write(input logic [2:0] idx, input logic w, input logic [13:0] tag, input logic v);
    bus.wr_en = 1; bus.wr_index = idx; bus.wr_way = w; bus.wr_tag = tag; bus.wr_valid = v;
    tick();
    bus.wr_en = 0;
  endtask

  task automatic do_lookup(input logic [2:0] idx, input logic [13:0] tag);
    bus.lk_req = 1; bus.lk_index = idx; bus.lk_tag = tag;
    tick();
    bus.lk_req = 0;
  endtask

  // counts sample points with busy=1, starting from the current one
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 50) begin
      cnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    int cnt;
    bus_idle();
    rst = 1;
    tick(); tick();
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got=%b exp=1", bus.busy); end
    n_chk++; if ({bus.resp_valid, bus.hit, bus.hit_way, bus.multi_hit, bus.resp_vmask} !== 6'b0) begin
      n_fail++; $display("FAIL reset_outs got rv=%b hit=%b way=%b multi=%b vm=%b exp=0",
                         bus.resp_valid, bus.hit, bus.hit_way, bus.multi_hit, bus.resp_vmask); end
    rst = 0;
    count_busy(cnt);
    n_chk++; if (cnt !== 8) begin n_fail++; $display("FAIL reset_clear_len got=%0d exp=8", cnt); end
    do_lookup(3'd5, 14'h0000);
    n_chk++; if (bus.resp_valid !== 1'b1 || bus.hit !== 1'b0 || bus.resp_vmask !== 2'b00) begin
      n_fail++; $display("FAIL post_reset_lookup got rv=%b hit=%b vm=%b exp rv=1 hit=0 vm=00",
                         bus.resp_valid, bus.hit, bus.resp_vmask); end
    tick();
    n_chk++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL resp_one_cycle got=%b exp=0", bus.resp_valid); end
  endtask

  task automatic test_write_lookup();
    do_write(3'd2, 1'b1, 14'h1ABC, 1'b1);
    do_lookup(3'd2, 14'h1ABC);
    n_chk++; if ({bus.resp_valid, bus.hit, bus.hit_way, bus.multi_hit, bus.resp_vmask} !== 6'b111010) begin
      n_fail++; $display("FAIL wr_hit got rv=%b hit=%b way=%b multi=%b vm=%b exp 1 1 1 0 10",
                         bus.resp_valid, bus.hit, bus.hit_way, bus.multi_hit, bus.resp_vmask); end
    do_lookup(3'd2, 14'h1ABD);
    n_chk++; if (bus.resp_valid !== 1'b1 || bus.hit !== 1'b0 || bus.resp_vmask !== 2'b10) begin
      n_fail++; $display("FAIL tag_miss got rv=%b hit=%b vm=%b exp 1 0 10", bus.resp_valid, bus.hit, bus.resp_vmask); end
  endtask

  task automatic test_same_cycle();
    bus.wr_en = 1; bus.wr_index = 3'd4; bus.wr_way = 1'b0; bus.wr_tag = 14'h0123; bus.wr_valid = 1;
    bus.lk_req = 1; bus.lk_index = 3'd4; bus.lk_tag = 14'h0123;
    tick();
    bus.wr_en = 0; bus.lk_req = 0;
`ifdef TAG_RAM_WR_BYPASS_EN
    n_chk++; if (bus.hit !== 1'b1 || bus.hit_way !== 1'b0 || bus.resp_vmask !== 2'b01) begin
      n_fail++; $display("FAIL same_cycle_bypass got hit=%b way=%b vm=%b exp 1 0 01", bus.hit, bus.hit_way, bus.resp_vmask); end
`else
    n_chk++; if (bus.hit !== 1'b0 || bus.resp_vmask !== 2'b00) begin
      n_fail++; $display("FAIL same_cycle_rbw got hit=%b vm=%b exp 0 00", bus.hit, bus.resp_vmask); end
`endif
    do_lookup(3'd4, 14'h0123);
    n_chk++; if (bus.hit !== 1'b1 || bus.hit_way !== 1'b0 || bus.resp_vmask !== 2'b01) begin
      n_fail++; $display("FAIL same_cycle_after got hit=%b way=%b vm=%b exp 1 0 01", bus.hit, bus.hit_way, bus.resp_vmask); end
  endtask

  task automatic test_multi_hit();
    do_write(3'd7, 1'b0, 14'h0055, 1'b1);
    do_write(3'd7, 1'b1, 14'h0055, 1'b1);
    do_lookup(3'd7, 14'h0055);
    n_chk++; if ({bus.hit, bus.hit_way, bus.multi_hit, bus.resp_vmask} !== 5'b10111) begin
      n_fail++; $display("FAIL multi_hit got hit=%b way=%b multi=%b vm=%b exp 1 0 1 11",
                         bus.hit, bus.hit_way, bus.multi_hit, bus.resp_vmask); end
    do_write(3'd7, 1'b0, 14'h0055, 1'b0);
    do_lookup(3'd7, 14'h0055);
    n_chk++; if ({bus.hit, bus.hit_way, bus.multi_hit, bus.resp_vmask} !== 5'b11010) begin
      n_fail++; $display("FAIL invalidate_way got hit=%b way=%b multi=%b vm=%b exp 1 1 0 10",
                         bus.hit, bus.hit_way, bus.multi_hit, bus.resp_vmask); end
  endtask

  task automatic test_flush();
    int cnt;
    do_write(3'd0, 1'b0, 14'h0AAA, 1'b1);
    bus.flush = 1;
    bus.lk_req = 1; bus.lk_index = 3'd0; bus.lk_tag = 14'h0AAA;
    bus.wr_en = 1; bus.wr_index = 3'd0; bus.wr_way = 1'b1; bus.wr_tag = 14'h3333; bus.wr_valid = 1;
    tick();
    bus.flush = 0; bus.wr_en = 0;
    n_chk++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL flush_wins got rv=%b busy=%b exp rv=0 busy=1", bus.resp_valid, bus.busy); end
    cnt = 0;
    while (bus.busy && cnt < 50) begin
      cnt++;
      bus.lk_req = 1; bus.lk_index = 3'd7; bus.lk_tag = 14'h0055;
      tick();
      n_chk++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL busy_drop got rv=%b exp=0 at %0d", bus.resp_valid, cnt); end
    end
    bus.lk_req = 0;
    n_chk++; if (cnt !== 8) begin n_fail++; $display("FAIL flush_clear_len got=%0d exp=8", cnt); end
    do_lookup(3'd0, 14'h0AAA);
    n_chk++; if (bus.resp_valid !== 1'b1 || bus.hit !== 1'b0 || bus.resp_vmask !== 2'b00) begin
      n_fail++; $display("FAIL flushed_idx0 got rv=%b hit=%b vm=%b exp 1 0 00", bus.resp_valid, bus.hit, bus.resp_vmask); end
    do_lookup(3'd7, 14'h0055);
    n_chk++; if (bus.resp_valid !== 1'b1 || bus.hit !== 1'b0 || bus.resp_vmask !== 2'b00) begin
      n_fail++; $display("FAIL flushed_idx7 got rv=%b hit=%b vm=%b exp 1 0 00", bus.resp_valid, bus.hit, bus.resp_vmask); end
  endtask

  task automatic test_back_to_back();
    int cnt;
    bus.lk_req = 1; bus.lk_index = 3'd2; bus.lk_tag = 14'h0000;
    rst = 1;
    tick();
    bus.lk_req = 0;
    n_chk++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_cancels_lookup got rv=%b busy=%b exp 0 1", bus.resp_valid, bus.busy); end
    rst = 0;
    tick(); tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    count_busy(cnt);
    n_chk++; if (cnt !== 8) begin n_fail++; $display("FAIL midclear_reset_len got=%0d exp=8", cnt); end
    do_write(3'd7, 1'b1, 14'h2222, 1'b1);
    do_write(3'd0, 1'b0, 14'h1111, 1'b1);
    bus.lk_req = 1; bus.lk_index = 3'd7; bus.lk_tag = 14'h2222;
    tick();
    n_chk++; if ({bus.resp_valid, bus.hit, bus.hit_way, bus.resp_vmask} !== 5'b11110) begin
      n_fail++; $display("FAIL b2b_first got rv=%b hit=%b way=%b vm=%b exp 1 1 1 10",
                         bus.resp_valid, bus.hit, bus.hit_way, bus.resp_vmask); end
    bus.lk_index = 3'd0; bus.lk_tag = 14'h1111;
    tick();
    bus.lk_req = 0;
    n_chk++; if ({bus.resp_valid, bus.hit, bus.hit_way, bus.resp_vmask} !== 5'b11001) begin
      n_fail++; $display("FAIL b2b_second got rv=%b hit=%b way=%b vm=%b exp 1 1 0 01",
                         bus.resp_valid, bus.hit, bus.hit_way, bus.resp_vmask); end
    tick();
    n_chk++; if (bus.resp_valid !== 1'b0 || bus.hit !== 1'b1 || bus.resp_vmask !== 2'b01) begin
      n_fail++; $display("FAIL b2b_hold got rv=%b hit=%b vm=%b exp 0 1 01", bus.resp_valid, bus.hit, bus.resp_vmask); end
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_write_lookup();
    test_same_cycle();
    test_multi_hit();
    test_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
